calc_keypad_entry: RTL
======================

Name: calc_keypad_entry

Overview:
Input front-end for the 4-bit calculator. Scans a 4x4 matrix keypad, debounces key presses, and decodes them into operands and an operator. Its o_a, o_b and o_selOperator outputs drive the calculator core's i_a, i_b and i_selOperator inputs, so it is the keypad-input counterpart of the FND display output path. It also produces a result-ready strobe and an entry-state code that tells the display which value to show.

Parameters:
SCAN_DIV, 1000, clock cycles each column is driven before the next (minimum 4)
DEBOUNCE_SCANS, 4, number of consecutive identical full scans required before a key is accepted (minimum 2)

Ports:
i_clk  input  1  system clock
i_reset  input  1  synchronous, active-high reset
i_row  input  4  keypad rows, active-low, externally pulled up; asynchronous
o_col  output  4  keypad column drive, one-hot active-low
o_a  output  4  operand A (0..15)
o_b  output  4  operand B (0..15)
o_selOperator  output  2  00 add, 01 sub, 10 mul, 11 div
o_state  output  2  00 entering A, 01 entering B, 10 showing result
o_keyValid  output  1  one-cycle pulse for each accepted key press
o_keyCode  output  4  code of the last accepted key; holds its value between pulses
o_valid  output  1  one-cycle pulse when '#' completes an expression
o_error  output  1  one-cycle pulse when a digit would overflow an operand

Behaviour:
- Reset: o_col=1110, o_a=o_b=0, o_selOperator=00, o_state=00, o_keyCode=0, all pulses 0. Scan counter, column index and debounce state are cleared. Reset mid-scan or mid-entry discards everything.
- Key map (row r, col c):
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: * 0 # D
  - Codes: digits 0-9 map to 0x0-0x9; A/B/C/D map to 0xA-0xD (operators 00/01/10/11); '*' maps to 0xE (clear); '#' maps to 0xF (equals).
- i_row passes through a 2-FF synchronizer before use.
- Scanning:
  - Each column is driven for SCAN_DIV cycles, in order col0 to col3, then wraps.
  - Rows are sampled in the last cycle of each column slot.
  - One scan = 4 slots = 4*SCAN_DIV cycles.
- Scan result:
  - NONE if no row was low during the scan.
  - KEY(code) if exactly one key was seen.
  - MULTI if two or more keys were seen; MULTI is treated as NONE for press detection.
- Debounce:
  - The stable state changes only after DEBOUNCE_SCANS consecutive identical scan results.
  - A press event fires only when the stable state goes from NONE to KEY.
  - A new key requires the stable state to return to NONE first. Holding a key, or rolling directly from one key to another, yields no second event.
- On a press event, o_keyValid=1 and o_keyCode=code take effect in the cycle after the last qualifying scan ends.
- Entry FSM: reacts in the cycle where o_keyValid=1; its outputs change on the next edge.
  - S_A (00):
    - digit d: A' = A*10 + d. If A' > 15, A is unchanged and o_error pulses.
    - operator: store op, go to S_B with B cleared to 0.
    - '#': ignored.
  - S_B (01):
    - digit: accumulates into B with the same rule.
    - operator: replaces op; B unchanged.
    - '#': o_valid pulses, go to S_SHOW.
  - S_SHOW (10):
    - digit d: A=d, B=0, op=00, go to S_A.
    - operator: A, B and op unchanged, stay.
    - '#': ignored.
  - '*' in any state: A=B=0, op=00, go to S_A. No o_error or o_valid pulse.
- o_valid and o_error are mutually exclusive and never last more than one cycle. o_keyValid accompanies every accepted key, including ignored ones.
- Operands, operator and state hold steady between accepted keys.

Test Plan:
Use SCAN_DIV=4 and DEBOUNCE_SCANS=3 (scan = 16 cycles) for all scenarios.
1. Reset: after reset, o_col=1110 and then cycles 1101, 1011, 0111 every 4 cycles. All outputs are 0.
2. Hold key '5' (row1/col1) with 2 bounce glitches in the first scan: exactly one o_keyValid, o_keyCode=5, o_a=5. Holding for 200 cycles gives no further pulses.
3. Keys 1, 2, B, 3, '#': o_a=12, o_selOperator=01, o_b=3, o_valid pulses once, o_state=10.
4. Keys 9, 9: the second 9 gives an o_error pulse and o_a stays 9. Then '*': o_a=0 and o_state=00.
5. Press 4 and 6 simultaneously (MULTI): no o_keyValid. Release both, then press 6: o_keyValid and o_a=6.
6. Assert i_reset mid-debounce of key '7' and deassert within 1 scan while the key is still held: o_a=0. The key is accepted only after a full DEBOUNCE_SCANS of identical scans after reset.

Source files
------------

// File: rtl/calc_keypad_entry.sv
// Keypad front-end for the 4-bit calculator: scans a 4x4 matrix, debounces whole scans,
// and runs the operand/operator entry state machine that feeds the calculator core.
module calc_keypad_entry #(
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [3:0] i_row,
  output logic [3:0] o_col,
  output logic [3:0] o_a,
  output logic [3:0] o_b,
  output logic [1:0] o_selOperator,
  output logic [1:0] o_state,
  output logic       o_keyValid,
  output logic [3:0] o_keyCode,
  output logic       o_valid,
  output logic       o_error
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int DB_W  = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [DB_W-1:0]  DB_FULL  = DB_W'(DEBOUNCE_SCANS);

  localparam logic [1:0] K_NONE  = 2'b00;
  localparam logic [1:0] K_KEY   = 2'b01;
  localparam logic [1:0] K_MULTI = 2'b10;

  typedef enum logic [1:0] {
    S_A    = 2'b00,
    S_B    = 2'b01,
    S_SHOW = 2'b10
  } state_t;

  function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] k;
    case ({r, c})
      4'b0000: k = 4'h1;
      4'b0001: k = 4'h2;
      4'b0010: k = 4'h3;
      4'b0011: k = 4'hA;
      4'b0100: k = 4'h4;
      4'b0101: k = 4'h5;
      4'b0110: k = 4'h6;
      4'b0111: k = 4'hB;
      4'b1000: k = 4'h7;
      4'b1001: k = 4'h8;
      4'b1010: k = 4'h9;
      4'b1011: k = 4'hC;
      4'b1100: k = 4'hE;
      4'b1101: k = 4'h0;
      4'b1110: k = 4'hF;
      default: k = 4'hD;
    endcase
    return k;
  endfunction

  function automatic logic [1:0] sat_count(input logic [2:0] n);
    return (n > 3'd2) ? 2'd2 : n[1:0];
  endfunction

  logic [3:0]       row_p0, row_p1;
  logic [CNT_W-1:0] div_cnt;
  logic [1:0]       col_idx;
  logic [1:0]       acc_n;
  logic [3:0]       acc_code;
  logic [5:0]       cand_res, stable_res;
  logic [DB_W-1:0]  same_cnt, same_nx;

  logic       slot_end, scan_end, press;
  logic [3:0] row_low, slot_code, tot_code;
  logic [2:0] slot_n;
  logic [1:0] tot_n, res_kind;
  logic [5:0] scan_res;

  logic       key_valid;
  logic [3:0] key_code_r;

  state_t     state, state_nx;
  logic [3:0] a_r, b_r, a_nx, b_nx;
  logic [1:0] op_r, op_nx;
  logic       valid_r, error_r, valid_nx, error_nx;
  logic [7:0] acc_val;

  assign slot_end = (div_cnt == CNT_LAST);
  assign scan_end = slot_end && (col_idx == 2'd3);
  assign o_col    = ~(4'b0001 << col_idx);

  // Per-slot sample merged with the running scan, so the full scan result exists in its last cycle
  always_comb begin
    row_low   = ~row_p1;
    slot_n    = 3'(row_low[0]) + 3'(row_low[1]) + 3'(row_low[2]) + 3'(row_low[3]);
    slot_code = 4'h0;
    for (int r = 3; r >= 0; r--) begin
      if (row_low[r]) slot_code = key_code(2'(r), col_idx);
    end
    tot_n    = sat_count(3'(acc_n) + slot_n);
    tot_code = (acc_n == 2'd0) ? slot_code : acc_code;
    res_kind = (tot_n == 2'd0) ? K_NONE : ((tot_n == 2'd1) ? K_KEY : K_MULTI);
    scan_res = {res_kind, (tot_n == 2'd1) ? tot_code : 4'h0};
  end

  always_comb begin
    if (scan_res != cand_res)    same_nx = DB_W'(1);
    else if (same_cnt < DB_FULL) same_nx = same_cnt + DB_W'(1);
    else                         same_nx = same_cnt;
    press = scan_end && (same_nx == DB_FULL) &&
            (stable_res[5:4] == K_NONE) && (scan_res[5:4] == K_KEY);
  end

  // Stage p0/p1: row synchronizer; scan timing, accumulation and debounce
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      row_p0     <= 4'hF;
      row_p1     <= 4'hF;
      div_cnt    <= '0;
      col_idx    <= 2'd0;
      acc_n      <= 2'd0;
      acc_code   <= 4'h0;
      cand_res   <= {K_NONE, 4'h0};
      stable_res <= {K_NONE, 4'h0};
      same_cnt   <= '0;
      key_valid  <= 1'b0;
      key_code_r <= 4'h0;
    end else begin
      row_p0    <= i_row;
      row_p1    <= row_p0;
      key_valid <= press;
      if (press) key_code_r <= scan_res[3:0];
      if (slot_end) begin
        div_cnt <= '0;
        col_idx <= col_idx + 2'd1;
        if (scan_end) begin
          acc_n    <= 2'd0;
          acc_code <= 4'h0;
          cand_res <= scan_res;
          same_cnt <= same_nx;
          if (same_nx == DB_FULL) stable_res <= scan_res;
        end else begin
          acc_n    <= tot_n;
          acc_code <= tot_code;
        end
      end else begin
        div_cnt <= div_cnt + CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_nx = state;
    a_nx     = a_r;
    b_nx     = b_r;
    op_nx    = op_r;
    valid_nx = 1'b0;
    error_nx = 1'b0;
    acc_val  = ((state == S_B) ? {4'b0, b_r} : {4'b0, a_r}) * 8'd10 + {4'b0, key_code_r};
    if (key_valid) begin
      if (key_code_r == 4'hE) begin
        a_nx     = 4'h0;
        b_nx     = 4'h0;
        op_nx    = 2'b00;
        state_nx = S_A;
      end else if (key_code_r == 4'hF) begin
        if (state == S_B) begin
          valid_nx = 1'b1;
          state_nx = S_SHOW;
        end
      end else if (key_code_r >= 4'hA) begin
        case (state)
          S_A: begin
            op_nx    = 2'(key_code_r - 4'hA);
            b_nx     = 4'h0;
            state_nx = S_B;
          end
          S_B:     op_nx = 2'(key_code_r - 4'hA);
          default: ;
        endcase
      end else begin
        case (state)
          S_SHOW: begin
            a_nx     = key_code_r;
            b_nx     = 4'h0;
            op_nx    = 2'b00;
            state_nx = S_A;
          end
          S_B: begin
            if (acc_val > 8'd15) error_nx = 1'b1;
            else                 b_nx     = acc_val[3:0];
          end
          default: begin
            if (acc_val > 8'd15) error_nx = 1'b1;
            else                 a_nx     = acc_val[3:0];
          end
        endcase
      end
    end
  end

  // Stage p2: entry state, operands and result strobes
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state   <= S_A;
      a_r     <= 4'h0;
      b_r     <= 4'h0;
      op_r    <= 2'b00;
      valid_r <= 1'b0;
      error_r <= 1'b0;
    end else begin
      state   <= state_nx;
      a_r     <= a_nx;
      b_r     <= b_nx;
      op_r    <= op_nx;
      valid_r <= valid_nx;
      error_r <= error_nx;
    end
  end

  assign o_a           = a_r;
  assign o_b           = b_r;
  assign o_selOperator = op_r;
  assign o_state       = state;
  assign o_keyValid    = key_valid;
  assign o_keyCode     = key_code_r;
  assign o_valid       = valid_r;
  assign o_error       = error_r;

endmodule
